// File: rtl/encoder_pkg.sv
// Shared types, sizes and helpers for the registered 8-to-3 encoder.
package encoder_pkg;

    localparam int IDX_W = 3;
    localparam int N_IN  = 8;

    typedef logic [IDX_W-1:0] idx_t;

    // True when two or more request bits are set. Clearing the lowest set
    // bit leaves something behind only if a second bit was present.
    function automatic logic popcount_ge2(input logic [N_IN-1:0] req);
        return (req & (req - N_IN'(1))) != '0;
    endfunction

endpackage

// File: rtl/encoder_if.sv
// Bundles the request lines and the registered encoder results so a
// request source and an encoder consumer can be wired with one handle.
interface encoder_if;
    import encoder_pkg::*;

    logic [N_IN-1:0] req;
    idx_t            out;
    logic            valid;
    logic            multi;

    // The request source drives req and observes the encoded result.
    modport master (output req, input out, input valid, input multi);

    // The encoder consumes req and drives the encoded result.
    modport slave (input req, output out, output valid, output multi);

endinterface

// File: rtl/encoder_core.sv
// Purely combinational priority encoder: index of the winning request,
// plus "any request" and "more than one request" flags.
module encoder_core
    import encoder_pkg::*;
#(
    parameter bit HIGH_PRIORITY = 1'b1
) (
    input  logic [N_IN-1:0] i_req,
    output idx_t            o_idx,
    output logic            o_any,
    output logic            o_multi
);

    // Scan in the order that lets the preferred end overwrite the other,
    // so the last set bit visited is the winner; no request yields index 0.
    always_comb begin
        o_idx = '0;
        if (HIGH_PRIORITY) begin
            for (int i = 0; i < N_IN; i++) begin
                if (i_req[i]) o_idx = idx_t'(i);
            end
        end else begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (i_req[i]) o_idx = idx_t'(i);
            end
        end
    end

    assign o_any   = |i_req;
    assign o_multi = popcount_ge2(i_req);

endmodule

// File: rtl/encoder.sv
// Registered 8-to-3 encoder: gathers the request lines, encodes them and
// presents index, valid and multi one cycle later, all aligned to clk.
module encoder
    import encoder_pkg::*;
#(
    parameter bit HIGH_PRIORITY = 1'b1
) (
    output idx_t out,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic in4,
    input  logic in5,
    input  logic in6,
    input  logic in7,
    input  logic in8,
    input  logic clk,
    input  logic rst_n,
    output logic valid,
    output logic multi
);

    logic [N_IN-1:0] w_req;
    idx_t            w_idx;
    logic            w_any;
    logic            w_multi;

    idx_t            r_out;
    logic            r_valid;
    logic            r_multi;

    assign w_req = {in8, in7, in6, in5, in4, in3, in2, in1};

    encoder_core #(
        .HIGH_PRIORITY (HIGH_PRIORITY)
    ) u_core (
        .i_req   (w_req),
        .o_idx   (w_idx),
        .o_any   (w_any),
        .o_multi (w_multi)
    );

    // Capture all three results together every cycle so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_out   <= w_idx;
            r_valid <= w_any;
            r_multi <= w_multi;
        end
    end

    assign out   = r_out;
    assign valid = r_valid;
    assign multi = r_multi;

endmodule

// File: tb/tb_encoder.sv
// Directed bench for encoder: one instance preferring the highest request
// and one preferring the lowest, fed identical request patterns.
module tb_encoder;
    import encoder_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    encoder_if busHi ();
    encoder_if busLo ();

    encoder #(.HIGH_PRIORITY(1'b1)) u_dutHi (
        .out   (busHi.out),
        .in1   (busHi.req[0]),
        .in2   (busHi.req[1]),
        .in3   (busHi.req[2]),
        .in4   (busHi.req[3]),
        .in5   (busHi.req[4]),
        .in6   (busHi.req[5]),
        .in7   (busHi.req[6]),
        .in8   (busHi.req[7]),
        .clk   (clk),
        .rst_n (rst_n),
        .valid (busHi.valid),
        .multi (busHi.multi)
    );

    encoder #(.HIGH_PRIORITY(1'b0)) u_dutLo (
        .out   (busLo.out),
        .in1   (busLo.req[0]),
        .in2   (busLo.req[1]),
        .in3   (busLo.req[2]),
        .in4   (busLo.req[3]),
        .in5   (busLo.req[4]),
        .in6   (busLo.req[5]),
        .in7   (busLo.req[6]),
        .in8   (busLo.req[7]),
        .clk   (clk),
        .rst_n (rst_n),
        .valid (busLo.valid),
        .multi (busLo.multi)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive both instances without waiting for a clock edge.
    task automatic setReq(input logic [7:0] pattern);
        busHi.req = pattern;
        busLo.req = pattern;
    endtask

    // Drive a pattern, let one rising edge capture it, then settle 1ns.
    task automatic applyStimulus(input logic [7:0] pattern);
        setReq(pattern);
        @(posedge clk);
        #1;
    endtask

    // Compare {out, valid, multi} of both instances against expectations.
    task automatic checkOutput(input string tag,
                               input logic [2:0] expHi, input logic [2:0] expLo,
                               input logic expValid, input logic expMulti);
        logic [4:0] obsHi;
        logic [4:0] obsLo;
        logic [4:0] wantHi;
        logic [4:0] wantLo;
        obsHi  = {busHi.out, busHi.valid, busHi.multi};
        obsLo  = {busLo.out, busLo.valid, busLo.multi};
        wantHi = {expHi, expValid, expMulti};
        wantLo = {expLo, expValid, expMulti};
        vectors++;
        assert (obsHi === wantHi) else begin
            miscompares++;
            $error("[TB] FAIL %s/hi: observed out,valid,multi=%b expected=%b", tag, obsHi, wantHi);
        end
        vectors++;
        assert (obsLo === wantLo) else begin
            miscompares++;
            $error("[TB] FAIL %s/lo: observed out,valid,multi=%b expected=%b", tag, obsLo, wantLo);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset held with random requests: outputs pinned at zero.
        rst_n = 1'b0;
        setReq(8'($urandom));
        #2;
        checkOutput("reset_async", 3'd0, 3'd0, 1'b0, 1'b0);
        applyStimulus(8'($urandom));
        checkOutput("reset_rand1", 3'd0, 3'd0, 1'b0, 1'b0);
        applyStimulus(8'($urandom) | 8'h81);
        checkOutput("reset_rand2", 3'd0, 3'd0, 1'b0, 1'b0);

        // Release reset between edges with all requests low.
        setReq(8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h00);
        checkOutput("post_reset_idle", 3'd0, 3'd0, 1'b0, 1'b0);

        // One-hot sweep in1..in8.
        applyStimulus(8'h01); checkOutput("onehot_in1", 3'd0, 3'd0, 1'b1, 1'b0);
        applyStimulus(8'h02); checkOutput("onehot_in2", 3'd1, 3'd1, 1'b1, 1'b0);
        applyStimulus(8'h04); checkOutput("onehot_in3", 3'd2, 3'd2, 1'b1, 1'b0);
        applyStimulus(8'h08); checkOutput("onehot_in4", 3'd3, 3'd3, 1'b1, 1'b0);
        applyStimulus(8'h10); checkOutput("onehot_in5", 3'd4, 3'd4, 1'b1, 1'b0);
        applyStimulus(8'h20); checkOutput("onehot_in6", 3'd5, 3'd5, 1'b1, 1'b0);
        applyStimulus(8'h40); checkOutput("onehot_in7", 3'd6, 3'd6, 1'b1, 1'b0);
        applyStimulus(8'h80); checkOutput("onehot_in8", 3'd7, 3'd7, 1'b1, 1'b0);

        // Activity followed by all-zero.
        applyStimulus(8'h10); checkOutput("in5_then", 3'd4, 3'd4, 1'b1, 1'b0);
        applyStimulus(8'h00); checkOutput("zero_after", 3'd0, 3'd0, 1'b0, 1'b0);

        // Multi-hot patterns.
        applyStimulus(8'h24); checkOutput("multi_in3_in6", 3'd5, 3'd2, 1'b1, 1'b1);
        applyStimulus(8'hFF); checkOutput("multi_all", 3'd7, 3'd0, 1'b1, 1'b1);
        applyStimulus(8'h03); checkOutput("multi_in1_in2", 3'd1, 3'd0, 1'b1, 1'b1);
        applyStimulus(8'hC0); checkOutput("multi_in7_in8", 3'd7, 3'd6, 1'b1, 1'b1);
        applyStimulus(8'h81); checkOutput("multi_in1_in8", 3'd7, 3'd0, 1'b1, 1'b1);

        // Mid-operation reset pulse between edges.
        applyStimulus(8'h80); checkOutput("pre_midreset", 3'd7, 3'd7, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkOutput("midreset_async", 3'd0, 3'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        #1 checkOutput("midreset_released", 3'd0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 checkOutput("midreset_resume", 3'd7, 3'd7, 1'b1, 1'b0);

        // Pulse in2 entirely between two edges while idle.
        applyStimulus(8'h00); checkOutput("glitch_base", 3'd0, 3'd0, 1'b0, 1'b0);
        #2 setReq(8'h02);
        #2 checkOutput("glitch_between", 3'd0, 3'd0, 1'b0, 1'b0);
        #2 setReq(8'h00);
        @(posedge clk);
        #1 checkOutput("glitch_after", 3'd0, 3'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/encoder.md
# encoder

Registered 8-to-3 binary encoder. Eight single-bit request lines `in1`…`in8` are encoded into a 3-bit index `out`, registered on `clk`, with status flags for "no input active" and "more than one input active". It sits between discrete request/strobe sources and downstream logic that needs a compact, glitch-free, clock-aligned index.

## Interface
- `HIGH_PRIORITY`, default 1. When more than one input is active: 1 means the highest-numbered input wins; 0 means the lowest-numbered input wins.
- `clk`  input  1  System clock; all state updates on its rising edge.
- `rst_n`  input  1  Reset, asynchronous and active-low. Clears all registers immediately.
- `out`  output  3  Registered encoded index: `in1` gives 3'd0, up to `in8` giving 3'd7. Port order: first positional.
- `in1` … `in8`  input  1 each  Request lines, synchronous to `clk`. Port order: positions 2–9, `in1` first.
- `valid`  output  1  Registered. 1 when at least one input was active at the sampling edge.
- `multi`  output  1  Registered. 1 when two or more inputs were active at the sampling edge.

## Operation
- The combinational stage forms `req[7:0] = {in8,…,in1}`.
- One-hot `req`: the index of the set bit (`in(k)` gives k−1).
- Multi-hot `req`: the index is chosen by `HIGH_PRIORITY`, and `multi` = 1.
- All-zero `req`: the index is 3'd0, `valid` = 0, `multi` = 0. `out` = 0 is therefore ambiguous; consumers qualify it with `valid`.
- The index, `valid` and `multi` are registered together every cycle. There is no enable and no hold.
- X or Z on an input is not handled specially. Inputs must be driven.

## Timing
- While `rst_n` = 0: `out` = 3'd0, `valid` = 0, `multi` = 0, asynchronously. They stay there until the first rising `clk` edge after `rst_n` goes high.
- Latency is 1 cycle. Inputs sampled at edge N appear on the outputs just after edge N.
- Throughput: a new input pattern every cycle.
- An input change between edges is invisible until the next edge. Outputs never glitch.
- Reset asserted mid-stream clears the outputs immediately. The pipeline does not resume until the first edge after deassertion, and no stale value reappears.
- Simultaneous reset deassertion and clock edge: implementation-defined. The bench avoids that case.

## Structure
- Package `encoder_pkg` holds:
  - `IDX_W = 3` and `N_IN = 8`.
  - The `idx_t` typedef (logic [2:0]).
  - Function `popcount_ge2` for multi-hot detection.
- Sub-module `encoder_core`: a purely combinational priority encoder. It takes `req[7:0]` and `HIGH_PRIORITY` and produces `idx`, `any`, `multi`.
- Top `encoder` contains the input concatenation, `encoder_core`, and one async-reset register stage for `out`, `valid` and `multi`.

## Test plan
- Reset: hold `rst_n` = 0 with random inputs. Then `out` = 0, `valid` = 0, `multi` = 0. Release `rst_n`; with all inputs 0, after one edge the outputs are unchanged.
- One-hot sweep: drive `in1` … `in8` in turn, one line high at a time, each for one or more cycles. One edge after each drive, `out` takes the values 0, 1, 2, 3, 4, 5, 6, 7 in order, with `valid` = 1 and `multi` = 0.
- All-zero after activity: `in5` = 1, then all 0. `out` goes 4 then 0, and `valid` goes 1 then 0.
- Multi-hot: `in3` = `in6` = 1. With `HIGH_PRIORITY` = 1, `out` = 5 and `multi` = 1. With `HIGH_PRIORITY` = 0, `out` = 2 and `multi` = 1. All eight high gives `out` = 7 (or 0 when `HIGH_PRIORITY` = 0).
- Mid-operation reset: with `in8` = 1 and `out` = 7, pulse `rst_n` low between edges. `out` goes to 0 immediately, then returns to 7 on the first edge after release.
- Inter-edge glitch: toggle `in2` high then low between two edges. `out` and `valid` stay unchanged.
